// File: rtl/nand_cpu_pkg.sv
// Shared NAND CPU types: ALU opcodes and the renamed-uop record held by the issue queue.
`ifndef NUM_D_REG
`define NUM_D_REG 64
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package nand_cpu_pkg;

  localparam int unsigned DAddrW           = $clog2(`NUM_D_REG);
  localparam int unsigned SAddrW           = $clog2(`NUM_S_REG);
  localparam int unsigned RobW             = $clog2(`ROB_SIZE);
  localparam int unsigned ImmW             = 16;
  localparam int unsigned IQ_DEPTH_DEFAULT = 8;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluShl, AluShr, AluPass
  } AluOp;

  typedef struct packed {
    logic [RobW-1:0]   rob_addr;
    AluOp              alu_op;
    logic [ImmW-1:0]   immdt;
    logic              use_ra;
    logic [DAddrW-1:0] ra_addr;
    logic              ra_ready;
    logic              use_rt;
    logic [DAddrW-1:0] rt_addr;
    logic              rt_ready;
    logic              write_dst;
    logic [DAddrW-1:0] rw_addr;
    logic [DAddrW-1:0] prev_rw_addr;
    logic [SAddrW-1:0] rs_addr;
    logic [SAddrW-1:0] prev_rs_addr;
  } iq_uop_t;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
module iq_age_select
  import nand_cpu_pkg::*;
#(
  parameter int unsigned L = IQ_DEPTH_DEFAULT
) (
  input  logic [L-1:0]         ready_i,
  input  logic [L-1:0][L-1:0]  age_i,    // age_i[i][j]: entry i is older than entry j
  output logic [L-1:0]         grant_o
);

  logic blocked;

  always_comb begin
    grant_o = '0;
    blocked = 1'b0;
    for (int i = 0; i < L; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < L; j++) begin
        blocked = blocked | (ready_i[j] & age_i[j][i]);
      end
      grant_o[i] = ready_i[i] & ~blocked;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue with tag wakeup and full flush.
// Define NAND_CPU_IQ_AGE_SELECT_EN for oldest-ready select; default is lowest-index select.
module issue_queue
  import nand_cpu_pkg::*;
#(
  parameter int unsigned L        = IQ_DEPTH_DEFAULT,
  parameter int unsigned NUM_WAKE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  iq_uop_t                           alloc_uop,
  input  logic [NUM_WAKE-1:0]               wake_valid,
  input  logic [NUM_WAKE-1:0][DAddrW-1:0]   wake_addr,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output iq_uop_t                           issue_uop,
  output logic [$clog2(L):0]                occupancy
);

  localparam int unsigned CntW = $clog2(L) + 1;

  iq_uop_t [L-1:0] ent_q, ent_d;
  logic [L-1:0]    valid_q, valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [L-1:0]    rdy, grant, free_oh;
  logic            alloc_fire, issue_fire;
  iq_uop_t         alloc_woken, sel_uop;

  function automatic logic woken(input logic [DAddrW-1:0] tag,
                                 input logic [NUM_WAKE-1:0] wv,
                                 input logic [NUM_WAKE-1:0][DAddrW-1:0] wa);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKE; k++) begin
      hit = hit | (wv[k] & (wa[k] == tag));
    end
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < L; i++) begin
      rdy[i] = valid_q[i] & (~ent_q[i].use_ra | ent_q[i].ra_ready)
                          & (~ent_q[i].use_rt | ent_q[i].rt_ready);
    end
  end

`ifdef NAND_CPU_IQ_AGE_SELECT_EN
  logic [L-1:0][L-1:0] age_q, age_d;

  iq_age_select #(
    .L(L)
  ) u_age_select (
    .ready_i (rdy),
    .age_i   (age_q),
    .grant_o (grant)
  );

  // New entry becomes younger than every slot; stale bits of free slots are rewritten on alloc.
  always_comb begin
    age_d = age_q;
    if (alloc_fire) begin
      for (int i = 0; i < L; i++) begin
        if (free_oh[i]) begin
          for (int j = 0; j < L; j++) begin
            age_d[i][j] = 1'b0;
            age_d[j][i] = (j != i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = L - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    free_oh = '0;
    for (int i = L - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  assign issue_valid = |rdy;
  assign alloc_ready = (cnt_q != CntW'(L));
  assign occupancy   = cnt_q;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign issue_fire  = issue_valid & issue_ready & ~flush;

  always_comb begin
    sel_uop = '0;
    for (int i = 0; i < L; i++) begin
      if (grant[i]) sel_uop = ent_q[i];
    end
    issue_uop = '0;
    if (issue_valid) begin
      issue_uop          = sel_uop;
      issue_uop.ra_ready = 1'b1;
      issue_uop.rt_ready = 1'b1;
    end
  end

  always_comb begin
    alloc_woken = alloc_uop;
    if (alloc_uop.use_ra && woken(alloc_uop.ra_addr, wake_valid, wake_addr)) begin
      alloc_woken.ra_ready = 1'b1;
    end
    if (alloc_uop.use_rt && woken(alloc_uop.rt_addr, wake_valid, wake_addr)) begin
      alloc_woken.rt_ready = 1'b1;
    end
  end

  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < L; i++) begin
      if (ent_q[i].use_ra && woken(ent_q[i].ra_addr, wake_valid, wake_addr)) begin
        ent_d[i].ra_ready = 1'b1;
      end
      if (ent_q[i].use_rt && woken(ent_q[i].rt_addr, wake_valid, wake_addr)) begin
        ent_d[i].rt_ready = 1'b1;
      end
    end
    if (issue_fire) valid_d = valid_d & ~grant;
    if (alloc_fire) begin
      for (int i = 0; i < L; i++) begin
        if (free_oh[i]) begin
          ent_d[i]   = alloc_woken;
          valid_d[i] = 1'b1;
        end
      end
    end
    unique case ({alloc_fire, issue_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      valid_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
